// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot/auto-reload modes; registered outputs update one cycle after inputs are sampled.
// No backpressure; hold pauses counting while running, and priority is clear > load > hold > count.
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             hold,
  input  logic             periodic,
  output logic [WIDTH-1:0] cnt,
  output logic             running,
  output logic             done,
  output logic             expire
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state_q, state_nx;
  logic [WIDTH-1:0] cnt_q, cnt_nx;
  logic [WIDTH-1:0] reload_q, reload_nx;
  logic             expire_q, expire_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_nx;
      cnt_q    <= cnt_nx;
      reload_q <= reload_nx;
      expire_q <= expire_nx;
    end
  end

  always_comb begin
    state_nx  = state_q;
    cnt_nx    = cnt_q;
    reload_nx = reload_q;
    expire_nx = 1'b0;

    if (clear) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else if (load) begin
      // A zero load is a cancel: nothing to count, so park in IDLE.
      cnt_nx    = load_val;
      reload_nx = load_val;
      state_nx  = (load_val != ZERO) ? RUN : IDLE;
    end else if (state_q == RUN && !hold) begin
      if (cnt_q > ONE) begin
        cnt_nx = cnt_q - ONE;
      end else begin
        // Terminal step; cnt==0 cannot occur in RUN but is treated as terminal so it never wraps.
        expire_nx = 1'b1;
        if (periodic) begin
          cnt_nx = reload_q;
        end else begin
          cnt_nx   = '0;
          state_nx = DONE;
        end
      end
    end
  end

  assign cnt     = cnt_q;
  assign running = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign expire  = expire_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed vector bench for countdown_timer: table of one-cycle stimulus/response records plus hand sequences.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       hold = 1'b0;
  logic       periodic = 1'b0;
  logic [3:0] cnt;
  logic       running;
  logic       done;
  logic       expire;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic       clear;
    logic       load;
    logic [3:0] lv;
    logic       hold;
    logic       per;
    logic [3:0] ecnt;
    logic       erun;
    logic       edone;
    logic       eexp;
  } vec_t;

  vec_t vecs[$];

  countdown_timer #(.WIDTH(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .hold     (hold),
    .periodic (periodic),
    .cnt      (cnt),
    .running  (running),
    .done     (done),
    .expire   (expire)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_out(input string tag, input int ecnt, input int erun,
                           input int edone, input int eexp);
    check({tag, " cnt"}, int'(cnt), ecnt);
    check({tag, " running"}, int'(running), erun);
    check({tag, " done"}, int'(done), edone);
    check({tag, " expire"}, int'(expire), eexp);
  endtask

  task automatic add(input logic c, input logic l, input logic [3:0] lv, input logic h,
                     input logic p, input logic [3:0] ec, input logic er,
                     input logic ed, input logic ee);
    vec_t v;
    v.clear = c; v.load = l; v.lv = lv; v.hold = h; v.per = p;
    v.ecnt = ec; v.erun = er; v.edone = ed; v.eexp = ee;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, let one rising edge pass, then sample 1 time unit later.
  task automatic run_vec(input vec_t v, input string tag);
    clear = v.clear; load = v.load; load_val = v.lv; hold = v.hold; periodic = v.per;
    @(posedge clk);
    #1;
    check_out(tag, int'(v.ecnt), int'(v.erun), int'(v.edone), int'(v.eexp));
  endtask

  task automatic step(input logic c, input logic l, input logic [3:0] lv, input logic h,
                      input logic p, input logic [3:0] ec, input logic er,
                      input logic ed, input logic ee, input string tag);
    vec_t v;
    v.clear = c; v.load = l; v.lv = lv; v.hold = h; v.per = p;
    v.ecnt = ec; v.erun = er; v.edone = ed; v.eexp = ee;
    run_vec(v, tag);
  endtask

  initial begin
    // one-shot 3: 3,2,1,0 with a single expire, then DONE ignores hold/periodic
    add(0,1,4'd3,0,0, 4'd3,1,0,0);
    add(0,0,4'd0,0,0, 4'd2,1,0,0);
    add(0,0,4'd0,0,0, 4'd1,1,0,0);
    add(0,0,4'd0,0,0, 4'd0,0,1,1);
    add(0,0,4'd0,0,0, 4'd0,0,1,0);
    add(0,0,4'd0,1,1, 4'd0,0,1,0);
    // periodic 4: 4,3,2,1,4,... expire every 4 cycles
    add(0,1,4'd4,0,1, 4'd4,1,0,0);
    add(0,0,4'd0,0,1, 4'd3,1,0,0);
    add(0,0,4'd0,0,1, 4'd2,1,0,0);
    add(0,0,4'd0,0,1, 4'd1,1,0,0);
    add(0,0,4'd0,0,1, 4'd4,1,0,1);
    add(0,0,4'd0,0,1, 4'd3,1,0,0);
    add(0,0,4'd0,0,1, 4'd2,1,0,0);
    add(0,0,4'd0,0,1, 4'd1,1,0,0);
    add(0,0,4'd0,0,1, 4'd4,1,0,1);
    // hold 2 cycles on load 5: expire at 7th edge after load
    add(0,1,4'd5,0,0, 4'd5,1,0,0);
    add(0,0,4'd0,0,0, 4'd4,1,0,0);
    add(0,0,4'd0,1,0, 4'd4,1,0,0);
    add(0,0,4'd0,1,0, 4'd4,1,0,0);
    add(0,0,4'd0,0,0, 4'd3,1,0,0);
    add(0,0,4'd0,0,0, 4'd2,1,0,0);
    add(0,0,4'd0,0,0, 4'd1,1,0,0);
    add(0,0,4'd0,0,0, 4'd0,0,1,1);
    // restart race: load on the cnt=1 cycle suppresses expire
    add(0,1,4'd2,0,0, 4'd2,1,0,0);
    add(0,0,4'd0,0,0, 4'd1,1,0,0);
    add(0,1,4'd6,0,0, 4'd6,1,0,0);
    add(0,0,4'd0,0,0, 4'd5,1,0,0);
    // clear in RUN, hold idle in IDLE, clear beats load
    add(1,0,4'd0,0,0, 4'd0,0,0,0);
    add(0,0,4'd0,1,1, 4'd0,0,0,0);
    add(0,1,4'd9,0,0, 4'd9,1,0,0);
    add(1,1,4'd7,0,0, 4'd0,0,0,0);
    // load 0 cancels to IDLE with no expire
    add(0,1,4'd3,0,1, 4'd3,1,0,0);
    add(0,1,4'd0,0,0, 4'd0,0,0,0);
    add(0,0,4'd0,0,1, 4'd0,0,0,0);
    // load 1 expires after one cycle; load from DONE restarts
    add(0,1,4'd1,0,0, 4'd1,1,0,0);
    add(0,0,4'd0,0,0, 4'd0,0,1,1);
    add(0,1,4'd2,0,0, 4'd2,1,0,0);
    add(0,0,4'd0,0,0, 4'd1,1,0,0);
    add(0,0,4'd0,0,1, 4'd2,1,0,1);

    // reset state while held in reset
    #12;
    check_out("reset", 0, 0, 0, 0);
    #10 reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++)
      run_vec(vecs[i], $sformatf("v%0d", i));

    // full-range one-shot: 15 down to 0, no wrap
    step(1,0,4'd0,0,0, 4'd0,0,0,0, "max_clr");
    step(0,1,4'd15,0,0, 4'd15,1,0,0, "max_load");
    for (int k = 14; k >= 1; k--)
      step(0,0,4'd0,0,0, 4'(k),1,0,0, $sformatf("max_%0d", k));
    step(0,0,4'd0,0,0, 4'd0,0,1,1, "max_end");
    step(0,0,4'd0,0,0, 4'd0,0,1,0, "max_after");

    // asynchronous reset between edges at cnt=3
    step(0,1,4'd5,0,0, 4'd5,1,0,0, "ar_load");
    step(0,0,4'd0,0,0, 4'd4,1,0,0, "ar_4");
    step(0,0,4'd0,0,0, 4'd3,1,0,0, "ar_3");
    #2 reset_n = 1'b0;
    #1;
    check_out("ar_async", 0, 0, 0, 0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    step(0,0,4'd0,0,0, 4'd0,0,0,0, "ar_rel1");
    step(0,0,4'd0,0,0, 4'd0,0,0,0, "ar_rel2");
    step(0,0,4'd0,0,0, 4'd0,0,0,0, "ar_rel3");
    step(0,1,4'd2,0,0, 4'd2,1,0,0, "ar_reload");
    step(0,0,4'd0,0,0, 4'd1,1,0,0, "ar_1");
    step(0,0,4'd0,0,0, 4'd0,0,1,1, "ar_end");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
